controle_navegacao: RTL and testbench

Left-hand wall-following navigation controller for the maze robot. It samples the front and left wall sensors, sequences 90° turn pulses toward the orientation block on `girar`, and issues advance commands to the motion datapath with a done handshake. It tracks heading and grid position internally and stops when the configured goal cell is reached. It sits between the sensor inputs and the orientation/motion blocks, clocked by `clockc3`.

---
 rtl/controle_navegacao.sv | 179 +++++++++++++++++
 tb/tb_controle_navegacao.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_navegacao.sv
// rtl/controle_navegacao.sv - left-hand wall-following navigation FSM with heading/position tracking
// Optional stuck detector enabled by STUCK_DETECT_EN.
module controle_navegacao #(
  parameter int X_W     = 4,
  parameter int Y_W     = 4,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 15
) (
  input  logic           clockc3,
  input  logic           reset,
  input  logic           start,
  input  logic           head,
  input  logic           left,
  input  logic           mov_done,
  output logic           girar,
  output logic           avancar,
  output logic [2:0]     rumo,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           chegou,
  output logic           travado
);

  typedef enum logic [2:0] {
    S_IDLE, S_SENSE, S_TURN, S_ADVANCE, S_DONE, S_STUCK
  } state_t;

  localparam logic [2:0] NORTE = 3'b001;
  localparam logic [2:0] OESTE = 3'b010;
  localparam logic [2:0] LESTE = 3'b011;
  localparam logic [2:0] SUL   = 3'b100;

  state_t         state_q;
  logic           girar_q, avancar_q, chegou_q, jtl_q;
  logic [2:0]     rumo_q;
  logic [1:0]     pulses_q;
  logic [X_W-1:0] pos_x_q, pos_x_d;
  logic [Y_W-1:0] pos_y_q, pos_y_d;
  logic           restart, adv_done, at_goal;

`ifdef STUCK_DETECT_EN
  logic [3:0] turn_cnt_q;
  logic       travado_q;
`endif

  function automatic logic [2:0] rot_left(input logic [2:0] r);
    case (r)
      NORTE:   rot_left = OESTE;
      OESTE:   rot_left = SUL;
      SUL:     rot_left = LESTE;
      default: rot_left = NORTE;
    endcase
  endfunction

  assign restart  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_STUCK);
  assign adv_done = (state_q == S_ADVANCE) && mov_done;
  assign at_goal  = (pos_x_q == X_W'(GOAL_X)) && (pos_y_q == Y_W'(GOAL_Y));

  // One-cell step in the current heading, saturating at the grid edges.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    case (rumo_q)
      NORTE: if (pos_y_q != '1) pos_y_d = pos_y_q + 1'b1;
      SUL:   if (pos_y_q != '0) pos_y_d = pos_y_q - 1'b1;
      LESTE: if (pos_x_q != '1) pos_x_d = pos_x_q + 1'b1;
      OESTE: if (pos_x_q != '0) pos_x_d = pos_x_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clockc3) begin
    if (reset) begin
      state_q   <= S_IDLE;
      girar_q   <= 1'b0;
      avancar_q <= 1'b0;
      chegou_q  <= 1'b0;
      jtl_q     <= 1'b0;
      rumo_q    <= NORTE;
      pulses_q  <= '0;
      pos_x_q   <= X_W'(START_X);
      pos_y_q   <= Y_W'(START_Y);
`ifdef STUCK_DETECT_EN
      travado_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_STUCK: begin
          if (restart) begin
            state_q  <= S_SENSE;
            pos_x_q  <= X_W'(START_X);
            pos_y_q  <= Y_W'(START_Y);
            rumo_q   <= NORTE;
            jtl_q    <= 1'b0;
            chegou_q <= 1'b0;
`ifdef STUCK_DETECT_EN
            travado_q <= 1'b0;
`endif
          end
        end
        S_SENSE: begin
          if (at_goal) begin
            state_q  <= S_DONE;
            chegou_q <= 1'b1;
          end else if (!left && !jtl_q) begin
            state_q  <= S_TURN;
            girar_q  <= 1'b1;
            rumo_q   <= rot_left(rumo_q);
            pulses_q <= 2'd0;
            jtl_q    <= 1'b1;
          end else if (!head) begin
            state_q   <= S_ADVANCE;
            avancar_q <= 1'b1;
          end else begin
            // Right turn realised as three left quarter-turns.
            state_q  <= S_TURN;
            girar_q  <= 1'b1;
            rumo_q   <= rot_left(rumo_q);
            pulses_q <= 2'd2;
          end
        end
        S_TURN: begin
          if (girar_q) begin
            girar_q <= 1'b0;
          end else if (pulses_q != 2'd0) begin
            girar_q  <= 1'b1;
            rumo_q   <= rot_left(rumo_q);
            pulses_q <= pulses_q - 2'd1;
          end else begin
`ifdef STUCK_DETECT_EN
            if (turn_cnt_q[3]) begin
              state_q   <= S_STUCK;
              travado_q <= 1'b1;
            end else begin
              state_q <= S_SENSE;
            end
`else
            state_q <= S_SENSE;
`endif
          end
        end
        S_ADVANCE: begin
          if (adv_done) begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            avancar_q <= 1'b0;
            jtl_q     <= 1'b0;
            state_q   <= S_SENSE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef STUCK_DETECT_EN
  // Pulses since the last completed advance; each girar high cycle is one pulse.
  always_ff @(posedge clockc3) begin
    if (reset || restart || adv_done) begin
      turn_cnt_q <= '0;
    end else if (girar_q) begin
      turn_cnt_q <= turn_cnt_q + 4'd1;
    end
  end
  assign travado = travado_q;
`else
  assign travado = 1'b0;
`endif

  assign girar   = girar_q;
  assign avancar = avancar_q;
  assign chegou  = chegou_q;
  assign rumo    = rumo_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;

endmodule

// File: tb/tb_controle_navegacao.sv
// tb/tb_controle_navegacao.sv - directed bench with a queue-based behavioural navigation model
module tb_controle_navegacao;

  localparam int SX = 0, SY = 0, GX = 1, GY = 0, MAXC = 15;
`ifdef STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic clockc3 = 1'b0;
  logic reset = 1'b1, start = 1'b0, head = 1'b1, left = 1'b1, mov_done = 1'b0;
  logic girar, avancar, chegou, travado;
  logic [2:0] rumo;
  logic [3:0] pos_x, pos_y;
  logic sg_girar, sg_avancar, sg_chegou, sg_travado;
  logic [2:0] sg_rumo;
  logic [3:0] sg_pos_x, sg_pos_y;

  always #5 clockc3 = ~clockc3;

  controle_navegacao #(.X_W(4), .Y_W(4), .START_X(SX), .START_Y(SY), .GOAL_X(GX), .GOAL_Y(GY)) dut (
    .clockc3(clockc3), .reset(reset), .start(start), .head(head), .left(left), .mov_done(mov_done),
    .girar(girar), .avancar(avancar), .rumo(rumo), .pos_x(pos_x), .pos_y(pos_y),
    .chegou(chegou), .travado(travado));

  // Start cell equals goal cell: must finish without any motion.
  controle_navegacao #(.X_W(4), .Y_W(4), .START_X(2), .START_Y(3), .GOAL_X(2), .GOAL_Y(3)) dut_sg (
    .clockc3(clockc3), .reset(reset), .start(start), .head(head), .left(left), .mov_done(mov_done),
    .girar(sg_girar), .avancar(sg_avancar), .rumo(sg_rumo), .pos_x(sg_pos_x), .pos_y(sg_pos_y),
    .chegou(sg_chegou), .travado(sg_travado));

  int passed = 0, total = 0;
  bit cmp_en = 1'b0;
  int av_cnt = 0, g_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: headings indexed counter-clockwise N=0, W=1, S=2, E=3.
  localparam int M_IDLE = 0, M_SENSE = 1, M_TURN = 2, M_ADV = 3, M_DONE = 4, M_STUCK = 5;
  int m_mode = M_IDLE, m_x = SX, m_y = SY, m_dir = 0;
  int m_jtl = 0, m_ch = 0, m_tr = 0, m_g = 0, m_av = 0, m_cnt = 0;
  int q[$];

  function automatic int code_of(input int d);
    case (d)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 3;
    endcase
  endfunction

  task automatic plan_turn(input int quarters);
    for (int i = 0; i < quarters; i++) begin
      q.push_back(1);
      q.push_back(0);
    end
  endtask

  task automatic next_slot();
    m_g = q.pop_front();
    if (m_g != 0) begin
      m_dir = (m_dir + 1) % 4;
      m_cnt++;
    end
  endtask

  always @(posedge clockc3) begin
    if (reset) begin
      m_mode = M_IDLE; m_x = SX; m_y = SY; m_dir = 0;
      m_jtl = 0; m_ch = 0; m_tr = 0; m_g = 0; m_av = 0; m_cnt = 0;
      q.delete();
    end else begin
      case (m_mode)
        M_IDLE, M_DONE, M_STUCK: if (start) begin
          m_mode = M_SENSE; m_x = SX; m_y = SY; m_dir = 0;
          m_jtl = 0; m_ch = 0; m_tr = 0; m_cnt = 0;
        end
        M_SENSE: begin
          if (m_x == GX && m_y == GY) begin
            m_mode = M_DONE; m_ch = 1;
          end else if (!left && m_jtl == 0) begin
            plan_turn(1); m_jtl = 1; m_mode = M_TURN; next_slot();
          end else if (!head) begin
            m_mode = M_ADV; m_av = 1;
          end else begin
            plan_turn(3); m_mode = M_TURN; next_slot();
          end
        end
        M_TURN: begin
          if (q.size() == 0) begin
            m_g = 0;
            if (STUCK_EN && m_cnt >= 8) begin
              m_mode = M_STUCK; m_tr = 1;
            end else begin
              m_mode = M_SENSE;
            end
          end else begin
            next_slot();
          end
        end
        M_ADV: if (mov_done) begin
          case (m_dir)
            0: m_y = (m_y < MAXC) ? m_y + 1 : m_y;
            1: m_x = (m_x > 0) ? m_x - 1 : 0;
            2: m_y = (m_y > 0) ? m_y - 1 : 0;
            default: m_x = (m_x < MAXC) ? m_x + 1 : m_x;
          endcase
          m_av = 0; m_jtl = 0; m_cnt = 0; m_mode = M_SENSE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clockc3) begin
    if (cmp_en) begin
      chk("cyc_girar", int'(girar), m_g);
      chk("cyc_avancar", int'(avancar), m_av);
      chk("cyc_rumo", int'(rumo), code_of(m_dir));
      chk("cyc_pos_x", int'(pos_x), m_x);
      chk("cyc_pos_y", int'(pos_y), m_y);
      chk("cyc_chegou", int'(chegou), m_ch);
      chk("cyc_travado", int'(travado), m_tr);
      chk("cyc_sg_motion", int'(sg_girar) + int'(sg_avancar), 0);
    end
    if (avancar) av_cnt++;
    if (girar) g_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clockc3);
  endtask

  initial begin
    bit seen;
    @(negedge clockc3);
    cmp_en = 1'b1;
    chk("rst_girar", int'(girar), 0);
    chk("rst_avancar", int'(avancar), 0);
    chk("rst_rumo", int'(rumo), 1);
    chk("rst_pos", int'(pos_x) + int'(pos_y), 0);
    chk("rst_chegou", int'(chegou), 0);
    chk("rst_travado", int'(travado), 0);
    chk("rst_sg_pos_x", int'(sg_pos_x), 2);
    tick(1);
    reset = 1'b0;

    // Straight advance north, mov_done two cycles after avancar rises
    head = 1'b0; left = 1'b1; av_cnt = 0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("sg_chegou_sense", int'(sg_chegou), 0);
    tick(1);
    chk("adv_rise", int'(avancar), 1);
    chk("sg_chegou_done", int'(sg_chegou), 1);
    chk("sg_pos_y", int'(sg_pos_y), 3);
    tick(2);
    mov_done = 1'b1; left = 1'b0; head = 1'b0;
    tick(1);
    mov_done = 1'b0;
    chk("adv_len", av_cnt, 3);
    chk("adv_pos_y", int'(pos_y), 1);
    chk("adv_rumo", int'(rumo), 1);
    chk("model_y", m_y, 1);

    // Left turn then advance west into the x=0 edge
    tick(1);
    chk("lt_girar", int'(girar), 1);
    chk("lt_rumo", int'(rumo), 2);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = avancar;
    end
    chk("lt_then_adv", int'(seen), 1);
    chk("lt_no_second_turn", int'(rumo), 2);
    mov_done = 1'b1; left = 1'b1; head = 1'b1;
    tick(1);
    mov_done = 1'b0;
    chk("sat_pos_x", int'(pos_x), 0);
    chk("sat_pos_y", int'(pos_y), 1);
    chk("sat_av_low", int'(avancar), 0);

    // Right turn from Norte, then one advance east onto the goal
    reset = 1'b1;
    tick(1);
    reset = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("rt_p1", int'(girar), 1);
    chk("rt_r1", int'(rumo), 2);
    tick(1);
    chk("rt_gap1", int'(girar), 0);
    tick(1);
    chk("rt_p2", int'(girar), 1);
    chk("rt_r2", int'(rumo), 4);
    tick(2);
    chk("rt_p3", int'(girar), 1);
    chk("rt_r3", int'(rumo), 3);
    chk("model_dir", m_dir, 3);
    chk("sg_chegou_restart", int'(sg_chegou), 1);
    head = 1'b0;
    tick(2);
    chk("rt_sense_quiet", int'(girar) + int'(avancar), 0);
    tick(1);
    chk("goal_adv", int'(avancar), 1);
    mov_done = 1'b1;
    tick(1);
    mov_done = 1'b0;
    chk("goal_pos_x", int'(pos_x), 1);
    chk("goal_chegou_early", int'(chegou), 0);
    tick(1);
    chk("goal_chegou", int'(chegou), 1);
    chk("model_chegou", m_ch, 1);
    tick(3);
    chk("goal_hold", int'(chegou), 1);
    chk("goal_no_adv", int'(avancar), 0);

    // Restart from DONE, then reset mid right turn
    start = 1'b1; head = 1'b1;
    tick(1);
    start = 1'b0;
    chk("rs_pos", int'(pos_x) + int'(pos_y), 0);
    chk("rs_rumo", int'(rumo), 1);
    chk("rs_chegou", int'(chegou), 0);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("mr_girar", int'(girar), 0);
    chk("mr_rumo", int'(rumo), 1);
    chk("mr_avancar", int'(avancar), 0);
    reset = 1'b0;
    tick(3);
    chk("idle_quiet", int'(girar), 0);

    // Walls everywhere: endless turning, or STUCK when detection is built in
    g_cnt = 0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    start = 1'b1; mov_done = 1'b1;
    tick(1);
    start = 1'b0; mov_done = 1'b0;
    tick(100);
    if (STUCK_EN) begin
      chk("stuck_pulses", g_cnt, 9);
      chk("stuck_flag", int'(travado), 1);
    end else begin
      chk("spin_continues", int'(g_cnt >= 30), 1);
      chk("spin_travado", int'(travado), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
